e203_clkgate_ctrl: RTL and testbench

E203_CLKGATE_CTRL -- requirements
Module: e203_clkgate_ctrl

---
 rtl/e203_clkgate_ctrl.sv | 141 ++++++++++++++
 tb/tb_e203_clkgate_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// e203_clkgate_ctrl
//   Idle-driven clock gating controller. Watches activity on the gated unit
//   and drops the gating-cell enable after a programmable run of idle cycles.
//   Any activity (busy, wake_req, force_on, test_mode) brings the clock back.
//
//   Optional feature macro: E203_CLKGATE_CTRL_WAKE_EN
//     defined   : leaving GATED passes through a WAKE phase of WAKE_DLY cycles
//                 with the clock running but clk_ready held low.
//     undefined : leaving GATED goes straight to RUN; WAKE_DLY is unused.
//
// Ports
//   clk         in   free-running clock (ungated side)
//   rst         in   synchronous active-high reset
//   test_mode   in   DFT override, counts as activity
//   busy        in   gated unit has outstanding work
//   wake_req    in   external wake request
//   force_on    in   software keep-clock-on
//   idle_thresh in   [CNT_W] idle cycles tolerated before gating (live)
//   clock_en    out  enable to the clock gating cell (registered)
//   clk_ready   out  gated clock running and stable (registered)
//   gated       out  clock currently stopped (registered)
// ---------------------------------------------------------------------------
module e203_clkgate_ctrl #(
    parameter int CNT_W    = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_mode,
    input  logic             busy,
    input  logic             wake_req,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic             clock_en,
    output logic             clk_ready,
    output logic             gated
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_COUNT = 2'd1,
        S_GATED = 2'd2,
        S_WAKE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clock_en_q, clock_en_d;
    logic             clk_ready_q, clk_ready_d;
    logic             gated_q, gated_d;
    logic             act;

`ifndef E203_CLKGATE_CTRL_WAKE_EN
    // Keeps WAKE_DLY referenced in the build that has no wake phase.
    logic unused_wake_last;
    assign unused_wake_last = |WAKE_LAST;
`endif

    assign act = busy | wake_req | force_on | test_mode;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (!act) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                end
            end
            S_COUNT: begin
                if (act) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= idle_thresh) begin
                    // Compare before increment: cnt never exceeds idle_thresh,
                    // so it cannot wrap even at the all-ones threshold.
                    state_d = S_GATED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GATED: begin
                if (act) begin
`ifdef E203_CLKGATE_CTRL_WAKE_EN
                    state_d = S_WAKE;
`else
                    state_d = S_RUN;
`endif
                    cnt_d = '0;
                end
            end
`ifdef E203_CLKGATE_CTRL_WAKE_EN
            S_WAKE: begin
                // Runs to completion regardless of activity.
                if (cnt_q == WAKE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so the
        // gating-cell enable comes straight off a flop.
        clock_en_d  = (state_d != S_GATED);
        clk_ready_d = (state_d == S_RUN) || (state_d == S_COUNT);
        gated_d     = (state_d == S_GATED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            clock_en_q  <= 1'b1;
            clk_ready_q <= 1'b1;
            gated_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clock_en_q  <= clock_en_d;
            clk_ready_q <= clk_ready_d;
            gated_q     <= gated_d;
        end
    end

    assign clock_en  = clock_en_q;
    assign clk_ready = clk_ready_q;
    assign gated     = gated_q;

endmodule

// File: tb/tb_e203_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e203_clkgate_ctrl
//   Directed bench for e203_clkgate_ctrl. A reference model tracks the run of
//   consecutive idle cycles and a remaining-wake-cycles count; a compare
//   process checks every output on every negedge, and literal checks at
//   hand-computed cycles pin the model's timing.
// ---------------------------------------------------------------------------
module tb_e203_clkgate_ctrl;

    localparam int CNT_W    = 8;
    localparam int WAKE_DLY = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             test_mode, busy, wake_req, force_on;
    logic [CNT_W-1:0] idle_thresh;
    logic             clock_en, clk_ready, gated;

    e203_clkgate_ctrl #(.CNT_W(CNT_W), .WAKE_DLY(WAKE_DLY)) dut (
        .clk         (clk),
        .rst         (rst),
        .test_mode   (test_mode),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .clock_en    (clock_en),
        .clk_ready   (clk_ready),
        .gated       (gated)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // Reference model: the clock stops once the idle streak (act low while
    // running) reaches idle_thresh+2 cycles; leaving the stopped state costs
    // WAKE_DLY not-ready cycles when the wake phase is built.
    bit m_gated     = 1'b0;
    int m_wake_left = 0;
    int m_streak    = 0;

    always @(posedge clk) begin
        logic a;
        a = busy | wake_req | force_on | test_mode;
        if (rst) begin
            m_gated = 1'b0; m_wake_left = 0; m_streak = 0;
        end else if (m_gated) begin
            if (a) begin
                m_gated  = 1'b0;
                m_streak = 0;
`ifdef E203_CLKGATE_CTRL_WAKE_EN
                m_wake_left = WAKE_DLY;
`endif
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            m_streak = 0;
        end else begin
            m_streak = a ? 0 : m_streak + 1;
            if (m_streak >= int'(idle_thresh) + 2) begin
                m_gated  = 1'b1;
                m_streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_clock_en",  clock_en,  !m_gated);
            chk("m_clk_ready", clk_ready, !m_gated && (m_wake_left == 0));
            chk("m_gated",     gated,     m_gated);
            chk("inv_en_gated", clock_en ^ gated, 1'b1);
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic idle_inputs();
        busy = 1'b0; wake_req = 1'b0; force_on = 1'b0; test_mode = 1'b0;
    endtask

    initial begin
        idle_inputs();
        idle_thresh = 8'd3;
        rst = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_clock_en",  clock_en,  1'b1);
        chk("rst_clk_ready", clk_ready, 1'b1);
        chk("rst_gated",     gated,     1'b0);

        // Continuous idle, threshold 3: clock stops at cycle 5.
        rst = 1'b0; cyc = 0;
        run_to(4);
        chk("t3_c4_clock_en", clock_en, 1'b1);
        run_to(5);
        chk("t3_c5_clock_en", clock_en, 1'b0);
        chk("t3_c5_gated",    gated,    1'b1);
        run_to(7);

        // One-cycle wake request while gated.
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        chk("wk_clock_en", clock_en, 1'b1);
        chk("wk_gated",    gated,    1'b0);
`ifdef E203_CLKGATE_CTRL_WAKE_EN
        chk("wk_ready0", clk_ready, 1'b0);
        step();
        chk("wk_ready1", clk_ready, 1'b0);
        step();
        chk("wk_ready2", clk_ready, 1'b1);
`else
        chk("wk_ready0", clk_ready, 1'b1);
`endif
        step(); step();

        // Busy pulse at cycle 3 restarts the idle count; stop at cycle 9.
        do_reset();
        run_to(3);
        busy = 1'b1;
        step();
        busy = 1'b0;
        run_to(8);
        chk("bp_c8_clock_en", clock_en, 1'b1);
        run_to(9);
        chk("bp_c9_clock_en", clock_en, 1'b0);

        // Threshold lowered below the running count gates on the next edge.
        do_reset();
        idle_thresh = 8'd10;
        run_to(5);
        idle_thresh = 8'd2;
        step();
        chk("lower_c6_gated", gated, 1'b1);

        // Threshold 0 gates at cycle 2; activity right then is not lost.
        do_reset();
        idle_thresh = 8'd0;
        run_to(1);
        chk("t0_c1_clock_en", clock_en, 1'b1);
        run_to(2);
        chk("t0_c2_clock_en", clock_en, 1'b0);
        busy = 1'b1;
        step();
        busy = 1'b0;
        chk("t0_c3_clock_en", clock_en, 1'b1);
        run_to(12);

        // force_on holds the clock on.
        do_reset();
        force_on = 1'b1;
        run_to(10);
        chk("force_clock_en", clock_en, 1'b1);
        force_on = 1'b0;
        run_to(14);

        // Maximum threshold: no wrap, gating at cycle 257.
        do_reset();
        idle_thresh = 8'd255;
        run_to(256);
        chk("t255_c256_clock_en", clock_en, 1'b1);
        run_to(257);
        chk("t255_c257_gated", gated, 1'b1);
        run_to(300);
        chk("t255_c300_gated", gated, 1'b1);
        test_mode = 1'b1;
        step();
        test_mode = 1'b0;
        chk("tm_clock_en", clock_en, 1'b1);
        run_to(305);

        // Reset while gated.
        do_reset();
        idle_thresh = 8'd0;
        run_to(4);
        chk("rg_pre_gated", gated, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rg_clock_en",  clock_en,  1'b1);
        chk("rg_clk_ready", clk_ready, 1'b1);
        chk("rg_gated",     gated,     1'b0);

`ifdef E203_CLKGATE_CTRL_WAKE_EN
        // Reset mid-wake.
        do_reset();
        run_to(4);
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        chk("rw_pre_ready", clk_ready, 1'b0);
        rst = 1'b1;
        busy = 1'b0;
        step();
        rst = 1'b0;
        chk("rw_clock_en",  clock_en,  1'b1);
        chk("rw_clk_ready", clk_ready, 1'b1);
        chk("rw_gated",     gated,     1'b0);
`endif

        // Mixed activity with a small live threshold; model checks each cycle.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            busy        = ($urandom_range(0, 9) == 0);
            wake_req    = ($urandom_range(0, 29) == 0);
            force_on    = ($urandom_range(0, 49) == 0);
            test_mode   = ($urandom_range(0, 79) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) idle_thresh = 8'($urandom_range(0, 6));
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
